div_unit: RTL



---
 rtl/div_unit_pkg.sv | 21 ++
 rtl/div_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle restoring divider: FSM state
// encoding and the handshake level names used between EX and the divider.
package div_unit_pkg;

   // Divider control states
   typedef enum logic [1:0] {
      DIV_FREE   = 2'd0,
      DIV_BYZERO = 2'd1,
      DIV_ON     = 2'd2,
      DIV_END    = 2'd3
   } div_state_t;

   // ready_o levels
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   // start_i levels
   localparam logic DIV_START = 1'b1;
   localparam logic DIV_STOP  = 1'b0;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU. Operands are latched on the start
// edge, DATA_W subtract-shift steps follow, then a sign fix-up produces
// {remainder, quotient}, which is held on result_o until EX drops start_i.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
);

   div_state_t              state;
   logic [CNT_W-1:0]        cnt;
   logic [2*DATA_W:0]       work;         // {partial remainder, dividend/quotient, 1}
   logic [DATA_W-1:0]       divisor_mag;
   logic                    neg_dividend;
   logic                    neg_divisor;
   logic                    signed_op;
   logic [2*DATA_W-1:0]     result_r;
   logic [DATA_W+1:0]       trial;        // one extra bit so the borrow is visible

   // Magnitude of an operand; only signed operations with a set MSB are negated.
   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                   input logic is_signed);
      return (is_signed && v[DATA_W-1]) ? -v : v;
   endfunction

   // Restore operand signs: quotient negative when signs differ,
   // remainder takes the sign of the dividend.
   function automatic logic [2*DATA_W-1:0] fix_sign(input logic [2*DATA_W:0] w,
                                                    input logic is_signed,
                                                    input logic neg_a,
                                                    input logic neg_b);
      logic [DATA_W-1:0] quo;
      logic [DATA_W-1:0] rem;
      quo = w[DATA_W-1:0];
      rem = w[2*DATA_W:DATA_W+1];
      if (is_signed && (neg_a ^ neg_b)) quo = -quo;
      if (is_signed && neg_a)           rem = -rem;
      return {rem, quo};
   endfunction

   // Trial subtraction of the divisor from the upper DATA_W+1 bits of the working register
   assign trial = {1'b0, work[2*DATA_W:DATA_W]} - {2'b00, divisor_mag};

   // Divider FSM: operand capture, iteration, fix-up and result handshake
   // NOTE: every register here is sequential state, so all writes use <=;
   // blocking writes would let later statements see same-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= DIV_FREE;
         cnt          <= '0;
         work         <= '0;
         divisor_mag  <= '0;
         neg_dividend <= 1'b0;
         neg_divisor  <= 1'b0;
         signed_op    <= 1'b0;
         result_r     <= '0;
         ready_o      <= DIV_RESULT_NOT_READY;
         result_o     <= '0;
      end else begin
         case (state)
            DIV_FREE: begin
               ready_o  <= DIV_RESULT_NOT_READY;
               result_o <= '0;
               if (start_i == DIV_START && !annul_i) begin
                  work         <= {{DATA_W{1'b0}}, magnitude(opdata1_i, signed_div_i), 1'b0};
                  divisor_mag  <= magnitude(opdata2_i, signed_div_i);
                  neg_dividend <= signed_div_i & opdata1_i[DATA_W-1];
                  neg_divisor  <= signed_div_i & opdata2_i[DATA_W-1];
                  signed_op    <= signed_div_i;
                  cnt          <= '0;
                  state        <= (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
               end
            end

            // Divide-by-zero spends two edges here so its result is reported
            // three edges after the start edge.
            DIV_BYZERO: begin
               if (annul_i) begin
                  state <= DIV_FREE;
               end else if (cnt == '0) begin
                  cnt <= CNT_W'(1);
               end else begin
                  result_r <= '0;
                  state    <= DIV_END;
               end
            end

            DIV_ON: begin
               if (annul_i) begin
                  state <= DIV_FREE;
               end else if (cnt != CNT_W'(DATA_W)) begin
                  if (trial[DATA_W+1]) begin
                     work <= {work[2*DATA_W-1:0], 1'b0};
                  end else begin
                     work <= {trial[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
                  end
                  cnt <= cnt + CNT_W'(1);
               end else begin
                  result_r <= fix_sign(work, signed_op, neg_dividend, neg_divisor);
                  state    <= DIV_END;
               end
            end

            // Result is committed: annul_i has no effect, hold until EX releases start_i
            DIV_END: begin
               if (start_i == DIV_STOP) begin
                  state    <= DIV_FREE;
                  ready_o  <= DIV_RESULT_NOT_READY;
                  result_o <= '0;
               end else begin
                  ready_o  <= DIV_RESULT_READY;
                  result_o <= result_r;
               end
            end

            default: state <= DIV_FREE;
         endcase
      end
   end

endmodule : div_unit
